// File: rtl/mem_access_seq_pkg.sv
// mem_access_seq_pkg: shared states, bus codes and funct3 constants for the MEM byte sequencer
package mem_access_seq_pkg;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STORE} state_e;
  localparam logic [1:0] RW_IDLE  = 2'b00;
  localparam logic [1:0] RW_LOAD  = 2'b01;
  localparam logic [1:0] RW_STORE = 2'b10;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  // Reserved widths (011/110/111) fall into the word case.
  function automatic logic [2:0] byte_count(input logic [2:0] f3);
    return f3[1] ? 3'd4 : f3[0] ? 3'd2 : 3'd1;
  endfunction
endpackage

// File: rtl/mem_load_ext.sv
// mem_load_ext: extends an assembled little-endian load buffer according to funct3
module mem_load_ext (
  input  logic [2:0]  funct3_i,
  input  logic [31:0] buf_i,
  output logic [31:0] data_o
);
  logic sb, sh;
  always_comb begin
    sb = ~funct3_i[2] & buf_i[7];
    sh = ~funct3_i[2] & buf_i[15];
    data_o = funct3_i[1] ? buf_i :
             funct3_i[0] ? {{16{sh}}, buf_i[15:0]} : {{24{sb}}, buf_i[7:0]};
  end
endmodule

// File: rtl/mem_access_seq.sv
// mem_access_seq: byte-serial load/store sequencer driving the MEM port of memacc_ctrl
module mem_access_seq
  import mem_access_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        is_store_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        flag_to_ctrl,
  output logic [1:0]  rw_to_ctrl,
  output logic [31:0] addr_to_ctrl,
  output logic [7:0]  data_to_ctrl,
  input  logic        r_from_ctrl,
  input  logic [7:0]  data_from_ctrl
);
  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d, f3_q, f3_d, n;
  logic [1:0]  cap_idx;
  logic [31:0] base_q, base_d, wdata_q, wdata_d, buf_q, buf_d, rdata_q, rdata_d, ext;
  logic        done_q, done_d;
  assign n       = byte_count(f3_q);
  assign cap_idx = cnt_q[1:0] - 2'd1;
  // Extension sees the buffer including the byte captured this cycle.
  mem_load_ext u_ext (.funct3_i(f3_q), .buf_i(buf_d), .data_o(ext));
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    f3_d         = f3_q;
    base_d       = base_q;
    wdata_d      = wdata_q;
    buf_d        = buf_q;
    rdata_d      = rdata_q;
    done_d       = 1'b0;
    rw_to_ctrl   = RW_IDLE;
    addr_to_ctrl = '0;
    data_to_ctrl = '0;
    case (state_q)
      S_IDLE: if (req_i && !done_q) begin
        state_d = is_store_i ? S_STORE : S_LOAD;
        cnt_d   = 3'd0;
        f3_d    = funct3_i;
        base_d  = addr_i;
        wdata_d = wdata_i;
      end
      S_LOAD: begin
        rw_to_ctrl   = (cnt_q < n) ? RW_LOAD : RW_IDLE;
        addr_to_ctrl = (cnt_q < n) ? base_q + {29'd0, cnt_q} : '0;
        if (cnt_q != 3'd0 && r_from_ctrl) buf_d[{cap_idx, 3'b000} +: 8] = data_from_ctrl;
        cnt_d   = (cnt_q == n) ? 3'd0 : cnt_q + 3'd1;
        state_d = (cnt_q == n) ? S_IDLE : S_LOAD;
        done_d  = (cnt_q == n);
        rdata_d = (cnt_q == n) ? ext : rdata_q;
      end
      S_STORE: begin
        rw_to_ctrl   = RW_STORE;
        addr_to_ctrl = base_q + {29'd0, cnt_q};
        data_to_ctrl = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
        cnt_d   = (cnt_q == n - 3'd1) ? 3'd0 : cnt_q + 3'd1;
        state_d = (cnt_q == n - 3'd1) ? S_IDLE : S_STORE;
        done_d  = (cnt_q == n - 3'd1);
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      f3_q    <= '0;
      base_q  <= '0;
      wdata_q <= '0;
      buf_q   <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      f3_q    <= f3_d;
      base_q  <= base_d;
      wdata_q <= wdata_d;
      buf_q   <= buf_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
    end
  end
  assign busy_o       = state_q != S_IDLE;
  assign flag_to_ctrl = state_q != S_IDLE;
  assign done_o       = done_q;
  assign rdata_o      = rdata_q;
  // RAM must deliver a byte in every load cycle that follows a read.
  a_rvalid: assert property (@(posedge clk) disable iff (rst)
    (state_q == S_LOAD && cnt_q != 3'd0) |-> r_from_ctrl);
endmodule

// File: tb/tb_mem_access_seq.sv
// tb_mem_access_seq: randomized and directed checks of mem_access_seq against a byte-memory model
module tb_mem_access_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_i = 1'b0;
  logic        is_store_i = 1'b0;
  logic [2:0]  funct3_i = 3'd0;
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic        busy_o, done_o, flag_to_ctrl;
  logic [31:0] rdata_o, addr_to_ctrl;
  logic [1:0]  rw_to_ctrl;
  logic [7:0]  data_to_ctrl;
  logic        r_from_ctrl = 1'b0;
  logic [7:0]  data_from_ctrl = 8'h00;
  int errors = 0;
  int checks = 0;
  logic [7:0] ram [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];

  mem_access_seq dut (
    .clk(clk), .rst(rst), .req_i(req_i), .is_store_i(is_store_i), .funct3_i(funct3_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .busy_o(busy_o), .done_o(done_o), .rdata_o(rdata_o),
    .flag_to_ctrl(flag_to_ctrl), .rw_to_ctrl(rw_to_ctrl), .addr_to_ctrl(addr_to_ctrl),
    .data_to_ctrl(data_to_ctrl), .r_from_ctrl(r_from_ctrl), .data_from_ctrl(data_from_ctrl)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction
  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : init_byte(a);
  endfunction
  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction

  // Byte RAM with one-cycle read latency, as seen through memacc_ctrl.
  always @(posedge clk) begin
    r_from_ctrl    <= (rw_to_ctrl == 2'b01);
    data_from_ctrl <= (rw_to_ctrl == 2'b01) ? ram_rd(addr_to_ctrl) : 8'h00;
    if (rw_to_ctrl == 2'b10) ram[addr_to_ctrl] = data_to_ctrl;
  end

  task automatic preload(input logic [31:0] a, input logic [7:0] b);
    ram[a] = b;
    ref_mem[a] = b;
  endtask

  // Called at a negedge of an idle cycle t; returns at the negedge of the done cycle with req_i held.
  task automatic run_access(input string tag, input logic st, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd);
    int n, last;
    logic [44:0] e_v, g_v;
    logic [31:0] er;
    n = f3[1] ? 4 : f3[0] ? 2 : 1;
    last = st ? n + 1 : n + 2;
    g_v = {busy_o, done_o, flag_to_ctrl, rw_to_ctrl, addr_to_ctrl, data_to_ctrl};
    checks++;
    if (g_v !== 45'd0) begin
      errors++;
      $display("FAIL %s idle-before got=%h exp=%h", tag, g_v, 45'd0);
    end
    er = '0;
    for (int i = 0; i < n; i++) er = er | ({24'd0, ref_rd(a + i)} << (8 * i));
    if (!st && !f3[2] && n < 4 && er[8 * n - 1]) er = er | ~((32'd1 << (8 * n)) - 32'd1);
    req_i = 1'b1; is_store_i = st; funct3_i = f3; addr_i = a; wdata_i = wd;
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      if (k <= n)
        e_v = {1'b1, 1'b0, 1'b1, st ? 2'b10 : 2'b01, a + (k - 1), st ? wd[8 * (k - 1) +: 8] : 8'h00};
      else if (k < last)
        e_v = {1'b1, 1'b0, 1'b1, 2'b00, 32'd0, 8'h00};
      else
        e_v = {1'b0, 1'b1, 1'b0, 2'b00, 32'd0, 8'h00};
      g_v = {busy_o, done_o, flag_to_ctrl, rw_to_ctrl, addr_to_ctrl, data_to_ctrl};
      checks++;
      if (g_v !== e_v) begin
        errors++;
        $display("FAIL %s cycle t+%0d bus got=%h exp=%h", tag, k, g_v, e_v);
      end
    end
    if (!st) begin
      checks++;
      if (rdata_o !== er) begin
        errors++;
        $display("FAIL %s rdata got=%h exp=%h", tag, rdata_o, er);
      end
    end else begin
      for (int i = 0; i < n; i++) ref_mem[a + i] = wd[8 * i +: 8];
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (ram_rd(a + i) !== ref_rd(a + i)) begin
          errors++;
          $display("FAIL %s ram[%h] got=%h exp=%h", tag, a + i, ram_rd(a + i), ref_rd(a + i));
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy_o, done_o, flag_to_ctrl, rw_to_ctrl, addr_to_ctrl, data_to_ctrl, rdata_o} !== 77'd0) begin
      errors++;
      $display("FAIL reset outputs got=%h exp=0",
               {busy_o, done_o, flag_to_ctrl, rw_to_ctrl, addr_to_ctrl, data_to_ctrl, rdata_o});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_loads();
    preload(32'h100, 8'h78); preload(32'h101, 8'h56);
    preload(32'h102, 8'h34); preload(32'h103, 8'h12);
    preload(32'h7, 8'h80);
    preload(32'hFFFF_FFFF, 8'h34); preload(32'h0, 8'h92);
    run_access("lw_100", 1'b0, 3'b010, 32'h100, 32'h0);
    checks++;
    if (rdata_o !== 32'h1234_5678) begin
      errors++;
      $display("FAIL lw_100 const got=%h exp=%h", rdata_o, 32'h1234_5678);
    end
    @(negedge clk); run_access("lb_7", 1'b0, 3'b000, 32'h7, 32'h0);
    @(negedge clk); run_access("lbu_7", 1'b0, 3'b100, 32'h7, 32'h0);
    @(negedge clk); run_access("lh_wrap", 1'b0, 3'b001, 32'hFFFF_FFFF, 32'h0);
    checks++;
    if (rdata_o !== 32'hFFFF_9234) begin
      errors++;
      $display("FAIL lh_wrap const got=%h exp=%h", rdata_o, 32'hFFFF_9234);
    end
    @(negedge clk); run_access("lhu_wrap", 1'b0, 3'b101, 32'hFFFF_FFFF, 32'h0);
    @(negedge clk); run_access("lres_011", 1'b0, 3'b011, 32'h101, 32'h0);
  endtask

  task automatic test_stores();
    @(negedge clk); run_access("sw_200", 1'b1, 3'b010, 32'h200, 32'hDEAD_BEEF);
    @(negedge clk); run_access("sh_300", 1'b1, 3'b001, 32'h300, 32'hDEAD_BEEF);
    @(negedge clk); run_access("sb_fff", 1'b1, 3'b000, 32'hFFFF_FFFF, 32'hCAFE_BA55);
    @(negedge clk); run_access("lw_300", 1'b0, 3'b010, 32'h300, 32'h0);
    @(negedge clk); run_access("lw_200", 1'b0, 3'b010, 32'h200, 32'h0);
  endtask

  task automatic test_reset_mid();
    req_i = 1'b0;
    @(negedge clk);
    req_i = 1'b1; is_store_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h100;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy_o, done_o, flag_to_ctrl, rw_to_ctrl, addr_to_ctrl, data_to_ctrl, rdata_o} !== 77'd0) begin
      errors++;
      $display("FAIL reset_mid outputs got=%h exp=0",
               {busy_o, done_o, flag_to_ctrl, rw_to_ctrl, addr_to_ctrl, data_to_ctrl, rdata_o});
    end
    rst = 1'b0; req_i = 1'b0;
    @(negedge clk);
    run_access("lb_after_rst", 1'b0, 3'b000, 32'h7, 32'h0);
  endtask

  task automatic test_back_to_back_random();
    logic [2:0] ld_f3 [8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
    logic st;
    logic [2:0] f3;
    logic [31:0] a;
    int gap;
    for (int it = 0; it < 40; it++) begin
      st  = 1'($urandom_range(0, 1));
      f3  = st ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 7)];
      a   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3)) : ($urandom & 32'h3FF);
      gap = $urandom_range(0, 2);
      if (gap != 0) req_i = 1'b0;
      repeat (gap + 1) @(negedge clk);
      run_access(st ? "rnd_store" : "rnd_load", st, f3, a, $urandom);
    end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_reset_mid();
    test_back_to_back_random();
    req_i = 1'b0;
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_access_seq.md
# mem_access_seq

Byte-serial load/store sequencer for the MEM stage. Takes one LB/LH/LW/LBU/LHU/SB/SH/SW request. Issues it one byte at a time on the MEM-side port of `memacc_ctrl`, which arbitrates the byte-wide RAM between IF and MEM. Assembles and extends load data, and holds `busy_o` as the MEM stall request until the access completes.

## Interface
Parameters:
- none. Widths come from shared defines (`` `DataAddrBus`` = 32, `` `ByteBus`` = 8).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high (`` `Enable``).
- `req_i`  in  1  access request. Held by the MEM stage until `done_o`.
- `is_store_i`  in  1  1 = store, 0 = load.
- `funct3_i`  in  3  RV32I funct3 for the access width and sign.
- `addr_i`  in  32  byte address; any alignment.
- `wdata_i`  in  32  store data; byte 0 = bits [7:0].
- `busy_o`  out  1  access in progress (stall request).
- `done_o`  out  1  one-cycle completion pulse.
- `rdata_o`  out  32  extended load result; valid when `done_o` = 1; held until the next load completes.
- `flag_to_ctrl`  out  1  bus owned by MEM; routes RAM read data to MEM, away from IF.
- `rw_to_ctrl`  out  2  00 idle, 01 load, 10 store.
- `addr_to_ctrl`  out  32  byte address for the current cycle.
- `data_to_ctrl`  out  8  store byte.
- `r_from_ctrl`  in  1  read byte valid.
- `data_from_ctrl`  in  8  read byte.

## Operation
- States: IDLE, LOAD, STORE. Registers: op, base address, wdata, `cnt` (0..4), 4-byte assembly buffer.
- Byte count N:
  - funct3[1:0] = 00 gives N = 1.
  - 01 gives N = 2.
  - 1x gives N = 4. Reserved codes 011/110/111 are treated as a word access; no trap is raised.
- Accept rule: `req_i` is accepted only when state = IDLE and `done_o` = 0. On accept, latch all inputs, set `cnt` = 0, and enter LOAD or STORE.
- LOAD:
  - While `cnt` < N: `rw_to_ctrl` = 01 and `addr_to_ctrl` = base + `cnt` (mod 2^32).
  - When `cnt` = N: `rw_to_ctrl` = 00 and `addr_to_ctrl` = 0.
  - Every LOAD cycle with `cnt` ≥ 1 captures `data_from_ctrl` into byte `cnt`−1, qualified by `r_from_ctrl`. `r_from_ctrl` = 0 in such a cycle is a protocol error and is checked by an assertion.
  - After the capture at `cnt` = N: go to IDLE, register `done_o` = 1, and load `rdata_o`.
- STORE:
  - While `cnt` < N: `rw_to_ctrl` = 10, `addr_to_ctrl` = base + `cnt`, `data_to_ctrl` = wdata byte `cnt`.
  - After the write at `cnt` = N−1: go to IDLE and register `done_o` = 1.
- Extension:
  - LB: sign-extend from byte 0 bit 7.
  - LH: sign-extend from byte 1 bit 7.
  - LBU/LHU: zero-extend.
  - LW: no extension.
- `busy_o` = `flag_to_ctrl` = (state ≠ IDLE). IF is therefore blocked for the entire store as well as the load.
- IDLE outputs: `rw_to_ctrl` = 00, `addr_to_ctrl` = 0, `data_to_ctrl` = 0.

## Timing
- `req_i` is sampled at the end of cycle t. Byte i is presented on the bus in cycle t+1+i. For loads, RAM data for byte i arrives in cycle t+2+i (one-cycle RAM read latency).
- Load: `done_o` fires in cycle t+N+2 (LB at t+3, LH at t+4, LW at t+6). `busy_o` is high during t+1 .. t+N+1.
- Store: `done_o` fires in cycle t+N+1 (SW at t+5). `busy_o` is high during t+1 .. t+N.
- In the done cycle, `busy_o` = 0. `req_i` still high from the same instruction is ignored. The pipeline advances at the end of that cycle. A new request can be sampled in the next cycle, which gives one dead cycle between back-to-back accesses.
- Reset values: `busy_o` 0, `done_o` 0, `rdata_o` 0, `flag_to_ctrl` 0, `rw_to_ctrl` 00, `addr_to_ctrl` 0, `data_to_ctrl` 0; state IDLE, `cnt` 0.
- Reset mid-access: the next cycle shows the reset values. No `done_o` is produced. Store bytes already written remain in RAM and there is no rollback.
- Address increment wraps at 0xFFFFFFFF → 0x00000000.

## Structure
- Shared `defines.v`:
  - `` `Enable``, `` `ZeroWord``, `` `ZeroByte``, `` `ByteBus``, `` `DataAddrBus``.
  - New RW codes `` `RwIdle``/`` `RwLoad``/`` `RwStore`` (00/01/10).
  - funct3 constants `` `F3_B``, `` `F3_H``, `` `F3_W``, `` `F3_BU``, `` `F3_HU``.
  - `memacc_ctrl` is to use the same RW codes.
- One sub-module, `mem_load_ext`: combinational; takes funct3 and the 4-byte buffer and produces the 32-bit extended result. Unit-testable in isolation.
- FSM, counter and buffers live in `mem_access_seq`.

## Test plan
- LW at 0x100, RAM bytes 78 56 34 12 → `addr_to_ctrl` = 0x100..0x103 in cycles t+1..t+4; `done_o` at t+6; `rdata_o` = 0x12345678.
- LB at 0x7 with byte 0x80 → `rdata_o` = 0xFFFFFF80 at t+3. LBU at the same address → 0x00000080.
- LH at 0xFFFFFFFF, bytes 34 92 → addresses 0xFFFFFFFF then 0x00000000; `rdata_o` = 0xFFFF9234. LHU → 0x00009234.
- SW 0xDEADBEEF at 0x200 → `rw_to_ctrl` = 10 during t+1..t+4, data EF BE AD DE, `done_o` at t+5. SH 0xDEADBEEF → only EF BE written, `done_o` at t+3.
- `rst` asserted in cycle t+2 of an LW → all outputs at reset values the next cycle; no `done_o`; a new request one cycle after `rst` deasserts is accepted normally.
- `req_i` held high through the done cycle → no re-issue. A new request presented in the cycle after `done_o` starts bus activity one cycle later.
